// File: rtl/fir_bist_pkg.sv
// Shared types and constants for the FIR BIST driver and its LFSR.
// No logic here; latency and backpressure are not applicable.
package fir_bist_pkg;

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DRAIN} state_t;

  localparam int LFSR_W      = 7;
  localparam int LFSR_TAP_HI = 6;
  localparam int LFSR_TAP_LO = 5;

  localparam int XW = 2;
  localparam int YW = 3;

  localparam logic [7:0] FIRST_ERR_NONE = 8'hFF;

endpackage

// File: rtl/fir_bist_lfsr.sv
// 7-bit Fibonacci LFSR symbol source; symbol is combinational from state (0 cycles).
// No backpressure: advances only when told to, reloads SEED on load.
module fir_bist_lfsr
  import fir_bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 7'h01
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  output logic [XW-1:0] sym
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (load) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
    end
  end

  assign sym = lfsr_q[XW-1:0];

endmodule

// File: rtl/fir_bist_driver.sv
// PRBS stimulus + bit-exact FIR checker; compares y_in LAT cycles after x_out. Optional macro FIR_BIST_INJECT_EN.
// No backpressure: start is ignored while busy; results are final on the edge done rises.
module fir_bist_driver
  import fir_bist_pkg::*;
#(
  parameter int                  NTAPS = 2,
  parameter logic [2*NTAPS-1:0]  COEF  = {2'd1, 2'd1},
  parameter int                  LAT   = 1,
  parameter int                  LEN   = 16,
  parameter logic [LFSR_W-1:0]   SEED  = 7'h01
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef FIR_BIST_INJECT_EN
  input  logic          inject,
`endif
  input  logic [YW-1:0] y_in,
  output logic [XW-1:0] x_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic [7:0]    first_err
);

  localparam logic [7:0] FLUSH_LAST = 8'(NTAPS + LAT - 1);
  localparam logic [7:0] RUN_LAST   = 8'(LEN - 1);
  localparam logic [7:0] DRAIN_LAST = 8'((LAT > 0) ? LAT - 1 : 0);

  state_t              state;
  logic [7:0]          cnt;
  logic [XW-1:0]       x_sym;
  logic                run_x;
  logic                accept;
  logic [NTAPS*XW-1:0] win;
  logic [YW-1:0]       exp_now;
  logic [YW-1:0]       prod;
  logic                cmp_vld;
  logic [YW-1:0]       cmp_exp;
  logic [7:0]          cmp_idx;
  logic                mismatch;

  assign run_x  = (state == RUN);
  assign accept = (state == IDLE) && start;

  fir_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .advance (run_x),
    .sym     (x_sym)
  );

`ifdef FIR_BIST_INJECT_EN
  assign x_out = run_x ? (x_sym ^ {{(XW-1){1'b0}}, inject}) : '0;
`else
  assign x_out = run_x ? x_sym : '0;
`endif

  // Model window: tap 0 is the current symbol, older symbols above it.
  if (NTAPS > 1) begin : g_hist
    logic [(NTAPS-1)*XW-1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hist <= '0;
      end else if (accept) begin
        hist <= '0;
      end else if (run_x) begin
        hist[XW-1:0] <= x_sym;
        for (int k = 1; k < NTAPS - 1; k++) begin
          hist[k*XW +: XW] <= hist[(k-1)*XW +: XW];
        end
      end
    end

    assign win = {hist, x_sym};
  end else begin : g_nohist
    assign win = x_sym;
  end

  always_comb begin
    exp_now = '0;
    prod    = '0;
    for (int k = 0; k < NTAPS; k++) begin
      prod    = YW'(COEF[k*XW +: XW]) * YW'(win[k*XW +: XW]);
      exp_now = exp_now + prod;
    end
  end

  if (LAT > 0) begin : g_dl
    logic          dl_vld [LAT];
    logic [YW-1:0] dl_exp [LAT];
    logic [7:0]    dl_idx [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) begin
          dl_vld[i] <= 1'b0;
          dl_exp[i] <= '0;
          dl_idx[i] <= '0;
        end
      end else begin
        dl_vld[0] <= run_x;
        dl_exp[0] <= exp_now;
        dl_idx[0] <= cnt;
        for (int i = 1; i < LAT; i++) begin
          dl_vld[i] <= dl_vld[i-1];
          dl_exp[i] <= dl_exp[i-1];
          dl_idx[i] <= dl_idx[i-1];
        end
      end
    end

    assign cmp_vld = dl_vld[LAT-1];
    assign cmp_exp = dl_exp[LAT-1];
    assign cmp_idx = dl_idx[LAT-1];
  end else begin : g_nodl
    assign cmp_vld = run_x;
    assign cmp_exp = exp_now;
    assign cmp_idx = cnt;
  end

  assign mismatch = cmp_vld && (y_in != cmp_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      first_err <= FIRST_ERR_NONE;
    end else begin
      if (mismatch) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (first_err == FIRST_ERR_NONE) first_err <= cmp_idx;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FLUSH;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_cnt   <= '0;
            first_err <= FIRST_ERR_NONE;
          end
        end
        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RUN: begin
          if (cnt == RUN_LAST) begin
            cnt <= '0;
            if (LAT == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pass = done && (err_cnt == 8'd0);

endmodule

// File: tb/tb_fir_bist_driver.sv
// Scoreboarded bench: stimulus queues expected symbols/results, a negedge monitor compares them.
module tb_fir_bist_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start_s;
  logic [2:0] y_in, y_s;
  logic [1:0] x_out, x_s;
  logic       busy, done, pass, busy_s, done_s, pass_s;
  logic [7:0] err_cnt, first_err, err_s, first_s;
`ifdef FIR_BIST_INJECT_EN
  logic       inject, inject_s;
`endif

  int checks   = 0;
  int failures = 0;
  int y_mode   = 0;

  fir_bist_driver u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FIR_BIST_INJECT_EN
    .inject(inject),
`endif
    .y_in(y_in), .x_out(x_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err(first_err)
  );

  fir_bist_driver #(.LEN(255)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s),
`ifdef FIR_BIST_INJECT_EN
    .inject(inject_s),
`endif
    .y_in(y_s), .x_out(x_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_cnt(err_s), .first_err(first_s)
  );

  // Correct 2-tap all-ones FIR with one register of latency, for each instance.
  logic [1:0] fx_d = '0, sx_d = '0;
  logic [2:0] fy = '0, sy = '0;
  always @(posedge clk) begin
    fx_d <= x_out;
    fy   <= 3'(x_out) + 3'(fx_d);
    sx_d <= x_s;
    sy   <= 3'(x_s) + 3'(sx_d);
  end
  assign y_in = (y_mode == 1) ? 3'd0 : fy;
  assign y_s  = sy ^ 3'd1;

  typedef struct {int err; int first; int ps;} res_t;
  res_t       res_q[$];
  logic [1:0] sym_q[$];
  logic [1:0] xtab[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected symbols during RUN and expected results when done rises.
  int   bcyc   = 0;
  logic done_d = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sym_q.delete();
      res_q.delete();
      bcyc   = 0;
      done_d = 1'b0;
    end else begin
      if (done && !done_d) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL res_unexpected: done rose with no expected result");
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("err_cnt", err_cnt, r.err);
          check("first_err", first_err, r.first);
          check("pass", pass, r.ps);
          check("busy_len", bcyc, 20);
        end
      end
      if (busy) begin
        if (bcyc >= 3 && bcyc < 19 && sym_q.size() > 0) check("x_sym", x_out, sym_q.pop_front());
        bcyc++;
      end else begin
        bcyc = 0;
      end
      done_d = done;
    end
  end

  task automatic push_golden();
    for (int i = 0; i < 16; i++) sym_q.push_back(xtab[i]);
    res_q.push_back('{0, 255, 1});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: done not seen within %0d cycles, got 0 expected 1", name, limit);
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x_out"}, x_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_first_err"}, first_err, 255);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    xtab    = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3,
                2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
    rst_n   = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
`ifdef FIR_BIST_INJECT_EN
    inject   = 1'b0;
    inject_s = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Golden run, with a stray start while busy that must be ignored.
    push_golden();
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60, "golden");

    // Stuck-at-zero DUT: 11 of the 16 expected values are non-zero.
    y_mode = 1;
    res_q.push_back('{11, 0, 0});
    pulse_start();
    wait_done(60, "stuck");
    y_mode = 0;

    // Restart after done: results cleared the cycle after acceptance.
    push_golden();
    pulse_start();
    check("restart_done", done, 0);
    check("restart_err_cnt", err_cnt, 0);
    check("restart_first_err", first_err, 255);
    check("restart_busy", busy, 1);
    wait_done(60, "restart");

    // Abort mid-RUN at symbol 8, then re-run from SEED.
    push_golden();
    pulse_start();
    repeat (11) @(negedge clk);
    check("midrun_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_golden();
    pulse_start();
    wait_done(60, "rerun");

`ifdef FIR_BIST_INJECT_EN
    // Flip bit 0 of symbol 5: corrupts outputs 5 and 6.
    res_q.push_back('{2, 5, 0});
    pulse_start();
    repeat (8) @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    wait_done(60, "inject");
`endif

    // Every one of 255 compares wrong: count ends at exactly 255.
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    begin
      int n = 0;
      while (!done_s && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    check("sat_done", done_s, 1);
    check("sat_err_cnt", err_s, 255);
    check("sat_first_err", first_s, 0);
    check("sat_pass", pass_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_bist_driver.md
Name: fir_bist_driver

Overview:
- Stimulus source and response checker for the 2-bit-in / 3-bit-out FIR datapath. It is the driving end of the FIR's x/y interface.
- Generates a deterministic PRBS symbol stream on x_out.
- Runs a bit-exact FIR reference model, compares the DUT's y_in against it after a fixed latency, and reports pass/fail, error count and the index of the first error.
- Sits beside the FIR inside the top, selectable in place of external pins for self-test.

Parameters:
- NTAPS, 2, number of FIR taps modelled (1..4).
- COEF, {2'd1,2'd1}, packed unsigned 2-bit coefficients, tap 0 in the LSBs.
- LAT, 1, DUT latency in cycles from x_out to the corresponding y_in (0..4).
- LEN, 16, number of symbols per test run (1..255).
- SEED, 7'h01, LFSR seed; must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; starts a run when idle.
- y_in  in  3  FIR output from the DUT.
- x_out  out  2  symbol driven to the DUT.
- busy  out  1  high from the cycle after start is accepted until the run is complete.
- done  out  1  sticky high after a run completes; cleared when the next start is accepted.
- pass  out  1  done && err_cnt==0; low otherwise.
- err_cnt  out  8  mismatch count, saturating at 255.
- first_err  out  8  index of the first mismatching symbol; 8'hFF if there was none.

Behaviour:
- Reset (async, rst_n=0): state IDLE, x_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err=8'hFF, LFSR=SEED, model history=0, expected delay line=0.
- LFSR: 7-bit state s, feedback f=s[6]^s[5], next s={s[5:0],f}. The symbol is x=s[1:0]. The LFSR advances once per RUN cycle only.
- Model: exp[i] = sum over k=0..NTAPS-1 of COEF[k]*x[i-k], with x[<0]=0, truncated to 3 bits (mod 8).
- Expected values travel through a LAT-deep delay line, together with a valid bit and the symbol index.
- FSM states and transitions:
  - IDLE: x_out=0. start=1 -> FLUSH. On entry to FLUSH: clear done/err_cnt, set first_err=FF, reload LFSR=SEED, clear history.
  - FLUSH: hold x_out=0 for NTAPS+LAT cycles so the DUT history is zero, then -> RUN. No compares.
  - RUN: LEN cycles. Cycle i drives x_out=x[i] and pushes exp[i]/index i into the delay line. After LEN cycles -> DRAIN.
  - DRAIN: x_out=0 for LAT cycles; the delay line empties, then -> IDLE with done=1. If LAT=0, skip straight to IDLE.
- Compare: in the cycle where a valid entry leaves the delay line, compare y_in with exp.
  - On mismatch: err_cnt+=1, saturating at 255.
  - If first_err==FF, load first_err with the entry's index.
  - With LAT=0, y_in is compared in the same cycle as x_out.
- busy is high in FLUSH, RUN and DRAIN.
- start while busy is ignored. start in IDLE with done=1 restarts the run and clears the results.
- The last compare and done=1 land on the same edge, so err_cnt is final when done rises.
- Asserting rst_n mid-run aborts immediately to the reset state; no partial results are retained.

Optional Feature:
- Macro: FIR_BIST_INJECT_EN.
- Defined: adds input port inject (1 bit). While in RUN with inject=1, x_out[0] is inverted for that cycle only. The model still uses the true x, so the checker must detect the fault.
- Undefined: no inject port; x_out always equals the model symbol.

Decomposition:
- Package fir_bist_pkg holds:
  - state enum {IDLE, FLUSH, RUN, DRAIN};
  - LFSR width (7) and taps (6, 5);
  - XW=2, YW=3;
  - the no-error constant FIRST_ERR_NONE=8'hFF.
- Sub-module fir_bist_lfsr: 7-bit LFSR with load and advance inputs.
- The model, delay line and FSM stay in the top.

Test Plan:
- Golden run: defaults, loopback through a correct 2-tap all-ones FIR with LAT=1, start pulse.
  -> x_out during RUN begins 1,2,0,0,0,0,1,3; y_in matches 1,3,2,0,0,0,1,4.
  -> done=1, pass=1, err_cnt=0, first_err=FF, busy low 2+1+16+1 cycles after start is accepted.
- Stuck output: y_in tied to 3'd0, defaults.
  -> err_cnt equals the count of non-zero exp over 16 symbols, first_err=0, pass=0.
- Injection (FIR_BIST_INJECT_EN): correct DUT, inject pulsed in RUN cycle 5.
  -> err_cnt=2 (symbols 5 and 6 affected), first_err=5.
- Saturation: LEN=255, y_in forced to an always-wrong value (exp^1).
  -> err_cnt=255, no wrap.
- start while busy, and reset mid-RUN at cycle 8.
  -> The extra start is ignored.
  -> rst_n low: all outputs return to reset values within the same cycle (async). A following start re-runs the identical sequence from SEED.
- Restart: a second start after done.
  -> done clears the next cycle, err_cnt resets, and the result is identical to the first run.
